intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised multi-channel interrupt controller for the CPU core, replacing the single `irr`/`intr_en` request path. It latches up to NCH interrupt lines, each configurable as edge- or level-triggered and individually maskable. It arbitrates the lines by fixed priority and presents one request plus a per-channel vector to the core's special-register stage. It saves the return PC on trap entry, handshakes entry and return with the core, and exposes a small config register window.

## Interface
- NCH, 4, number of interrupt channels (1..32)
- XLEN, 32, data/PC width
- VEC_BASE, 32'h0000_0100, vector of channel 0
- VEC_STRIDE, 16, byte distance between consecutive channel vectors
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- irq_in  in  NCH  raw interrupt lines, already synchronous to clk
- core_intr_en  in  1  global interrupt enable from core SR
- core_pc  in  XLEN  PC of the next instruction to execute
- intr_take  in  1  core enters the trap this cycle
- intr_ret  in  1  core executes interrupt return this cycle
- irr  out  1  interrupt request to core (registered)
- intr_vec  out  XLEN  handler address for the requested channel (registered)
- intr_pc  out  XLEN  saved return PC
- ack  out  1  one-cycle pulse confirming trap entry
- active  out  1  handler in progress
- active_id  out  $clog2(NCH) (min 1)  channel being serviced
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0 MASK, 1 EDGE, 2 PENDING, 3 STATUS
- cfg_wdata  in  XLEN  write data; bits above NCH ignored
- cfg_rdata  out  XLEN  combinational read of the addressed register; unused bits 0

## Operation
- irq_q registers irq_in every cycle. Rise is defined as irq_in & ~irq_q.
- Edge channel (EDGE[i]=1): a rise sets pending[i]. Pending is cleared by a PENDING write with bit i = 1, or by trap entry on channel i.
- Level channel: pending[i] <= irq_in[i] every cycle. W1C and trap-entry clear have no effect on it.
- Pending set and clear in the same cycle on the same bit: set wins.
- eligible = pending & MASK. Lowest index has highest priority.
- STATUS read: bit0 = core_intr_en, bit1 = active, bits[8+:5] = active_id. Writes to STATUS are ignored.
- State IDLE: irr=0.
  - If core_intr_en && |eligible: go to REQ. Load sel_id from the priority encoder. Load intr_vec = VEC_BASE + sel_id*VEC_STRIDE, computed mod 2^XLEN.
- State REQ: irr=1.
  - Re-arbitrate each cycle. sel_id and intr_vec follow the highest-priority eligible channel.
  - If eligible becomes empty or core_intr_en drops: go to IDLE. irr falls next cycle.
  - On intr_take, the core takes the request using the intr_vec value visible in that same cycle:
    - intr_pc <= core_pc
    - active_id <= sel_id
    - clear pending[sel_id] if the channel is edge-triggered
    - ack <= 1 for one cycle
    - go to ACTIVE
- State ACTIVE: irr=0, active=1. No nesting; pending keeps accumulating. intr_ret moves to IDLE and clears active.
- intr_take outside REQ and intr_ret outside ACTIVE are ignored.
- Simultaneous intr_take and a higher-priority arrival: the take uses the registered sel_id. The arrival stays pending.

## Timing
- Reset (rst_n=0 at a rising edge) sets all of the following to 0:
  - registers: MASK, EDGE, pending, irq_q, intr_pc
  - outputs: irr, intr_vec, ack, active, active_id
  - state returns to IDLE
- Reset during REQ or ACTIVE aborts without any ack.
- Latency from irq_in rising (sampled at edge t), with channel unmasked and core_intr_en=1:
  - pending=1 after edge t
  - irr=1 after edge t+1
- intr_take at edge k:
  - ack=1, active=1, intr_pc valid during cycle k+1
  - irr=0 from cycle k+1
- intr_ret at edge r:
  - IDLE from cycle r+1
  - earliest new irr after edge r+1
- cfg writes take effect at the next edge. A MASK write changes eligibility from that edge.

## Structure
- Add to the shared CPU package:
  - typedef enum INTR_STATE {IDLE, REQ, ACTIVE}
  - localparams for cfg addresses 0..3 and STATUS bit positions
  - packed struct INTR_REQ {irr, intr_vec} for the core's SR inputs
- Sub-module `intr_prio_enc`: parametrised NCH-bit lowest-index priority encoder with valid output.

## Test plan
- Reset, then MASK=4'b0100, EDGE=4'b0100, pulse irq_in[2] one cycle -> pending=4'b0100 next cycle; irr=1 and intr_vec=0x120 one cycle later.
- In REQ, assert intr_take with core_pc=0x40 -> next cycle ack=1 (exactly one cycle), intr_pc=0x40, active_id=2, pending[2]=0, irr=0. Then intr_ret -> IDLE.
- MASK=4'b1111, all level; in ACTIVE on ch3, raise irq_in[1] and irq_in[3] -> no irr until intr_ret, then irr with intr_vec=0x110.
- Edge ch0 pending; write PENDING=1 in the same cycle as a second rise on irq_in[0] -> pending[0] stays 1.
- In REQ with core_intr_en dropped to 0 -> irr=0 the next cycle. Separately, in REQ on ch2, raise irq_in[0] (MASK=4'b0101) -> intr_vec becomes 0x100 before take.
- Assert rst_n=0 for one edge while ACTIVE -> all outputs 0; a subsequent intr_ret is ignored.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared CPU interrupt-controller types: FSM states, config register map,
// STATUS bit layout and the request bundle fed to the core's SR stage.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } intr_state_e;

    localparam logic [1:0] CFG_MASK    = 2'd0;
    localparam logic [1:0] CFG_EDGE    = 2'd1;
    localparam logic [1:0] CFG_PENDING = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

    localparam int unsigned STATUS_EN_BIT     = 0;
    localparam int unsigned STATUS_ACTIVE_BIT = 1;
    localparam int unsigned STATUS_ID_LSB     = 8;
    localparam int unsigned STATUS_ID_W       = 5;

    localparam int unsigned INTR_XLEN = 32;

    typedef struct packed {
        logic                 irr;
        logic [INTR_XLEN-1:0] intr_vec;
    } intr_req_t;

    // Channel-id width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over NCH request bits.
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned AW  = id_width(NCH)
) (
    input  logic [NCH-1:0] req,
    output logic [AW-1:0]  id_c,
    output logic           valid_c
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        id_c    = '0;
        valid_c = |req;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) id_c = AW'(i);
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Multi-channel interrupt controller: latches edge/level lines, arbitrates by
// fixed priority, requests the core and tracks one non-nested handler.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter  int unsigned    NCH        = 4,
    parameter  int unsigned    XLEN       = 32,
    parameter  logic [XLEN-1:0] VEC_BASE  = XLEN'(32'h0000_0100),
    parameter  int unsigned    VEC_STRIDE = 16,
    localparam int unsigned    AW         = id_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  irq_in,
    input  logic            core_intr_en,
    input  logic [XLEN-1:0] core_pc,
    input  logic            intr_take,
    input  logic            intr_ret,
    output logic            irr,
    output logic [XLEN-1:0] intr_vec,
    output logic [XLEN-1:0] intr_pc,
    output logic            ack,
    output logic            active,
    output logic [AW-1:0]   active_id,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] cfg_rdata
);

    intr_state_e     state_q, state_d;
    logic [NCH-1:0]  mask_q, edge_q, pend_q, irq_q, pend_d;
    logic [NCH-1:0]  rise, eligible, w1c, take_clr;
    logic [AW-1:0]   sel_q, sel_d, enc_id;
    logic            enc_valid, take_c;
    logic [XLEN-1:0] vec_d, pc_d;
    logic [AW-1:0]   active_id_d;
    logic            irr_d, ack_d, active_d;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    function automatic logic [XLEN-1:0] vec_of(input logic [AW-1:0] id);
        return VEC_BASE + XLEN'(id) * XLEN'(VEC_STRIDE);
    endfunction

    assign rise     = irq_in & ~irq_q;
    assign eligible = pend_q & mask_q;

    intr_prio_enc #(.NCH(NCH)) u_prio_enc (
        .req     (eligible),
        .id_c    (enc_id),
        .valid_c (enc_valid)
    );

    // Edge channels: rise beats any clear; level channels just follow the line.
    always_comb begin
        w1c      = (cfg_we && cfg_addr == CFG_PENDING) ? cfg_wdata[NCH-1:0] : '0;
        take_clr = take_c ? (NCH'(1) << sel_q) : '0;
        pend_d   = (edge_q & (rise | (pend_q & ~(w1c | take_clr)))) | (~edge_q & irq_in);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        vec_d       = intr_vec;
        pc_d        = intr_pc;
        active_id_d = active_id;
        ack_d       = 1'b0;
        take_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_intr_en && enc_valid) begin
                    state_d = REQ;
                    sel_d   = enc_id;
                    vec_d   = vec_of(enc_id);
                end
            end
            REQ: begin
                if (intr_take) begin
                    take_c      = 1'b1;
                    state_d     = ACTIVE;
                    pc_d        = core_pc;
                    active_id_d = sel_q;
                    ack_d       = 1'b1;
                end else if (!core_intr_en || !enc_valid) begin
                    state_d = IDLE;
                end else begin
                    sel_d = enc_id;
                    vec_d = vec_of(enc_id);
                end
            end
            ACTIVE: begin
                if (intr_ret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irr_d    = (state_d == REQ);
        active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            irr       <= 1'b0;
            intr_vec  <= '0;
            intr_pc   <= '0;
            ack       <= 1'b0;
            active    <= 1'b0;
            active_id <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            irr       <= irr_d;
            intr_vec  <= vec_d;
            intr_pc   <= pc_d;
            ack       <= ack_d;
            active    <= active_d;
            active_id <= active_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
            edge_q <= '0;
            pend_q <= '0;
            irq_q  <= '0;
        end else begin
            irq_q  <= irq_in;
            pend_q <= pend_d;
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_MASK: mask_q <= cfg_wdata[NCH-1:0];
                    CFG_EDGE: edge_q <= cfg_wdata[NCH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Config read window; unused bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_MASK:    cfg_rdata = XLEN'(mask_q);
            CFG_EDGE:    cfg_rdata = XLEN'(edge_q);
            CFG_PENDING: cfg_rdata = XLEN'(pend_q);
            default: begin
                cfg_rdata[STATUS_EN_BIT]                    = core_intr_en;
                cfg_rdata[STATUS_ACTIVE_BIT]                = active;
                cfg_rdata[STATUS_ID_LSB +: STATUS_ID_W]     = STATUS_ID_W'(active_id);
            end
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboarded bench for intr_ctrl: directed scenarios then random traffic,
// expectations from a behavioural model, checked by an independent monitor.
module tb_intr_ctrl;

    localparam int unsigned NCH  = 4;
    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  irq_in;
    logic            core_intr_en;
    logic [XLEN-1:0] core_pc;
    logic            intr_take;
    logic            intr_ret;
    logic            irr;
    logic [XLEN-1:0] intr_vec;
    logic [XLEN-1:0] intr_pc;
    logic            ack;
    logic            active;
    logic [1:0]      active_id;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [XLEN-1:0] cfg_wdata;
    logic [XLEN-1:0] cfg_rdata;

    intr_ctrl #(.NCH(NCH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .core_intr_en (core_intr_en),
        .core_pc      (core_pc),
        .intr_take    (intr_take),
        .intr_ret     (intr_ret),
        .irr          (irr),
        .intr_vec     (intr_vec),
        .intr_pc      (intr_pc),
        .ack          (ack),
        .active       (active),
        .active_id    (active_id),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        irr;
        bit [31:0] vec;
        bit [31:0] pc;
        bit        ack;
        bit        active;
        bit [1:0]  aid;
        bit [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: 0 = idle, 1 = requesting, 2 = handler running.
    bit [3:0]  m_mask, m_edge, m_pend, m_prev;
    int        m_state, m_sel, m_aid;
    bit [31:0] m_vec, m_pc;
    bit        m_ack;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    task automatic cyc(input bit rst, input bit [3:0] irq, input bit en, input bit [31:0] pc,
                       input bit take, input bit ret, input bit we, input bit [1:0] addr,
                       input bit [31:0] wd);
        bit [3:0] elig, np;
        int       first;
        bit       tk;
        exp_t     e;
        @(negedge clk);
        rst_n = rst; irq_in = irq; core_intr_en = en; core_pc = pc;
        intr_take = take; intr_ret = ret; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
        if (!rst) begin
            m_mask = 0; m_edge = 0; m_pend = 0; m_prev = 0;
            m_state = 0; m_sel = 0; m_aid = 0; m_vec = 0; m_pc = 0; m_ack = 0;
        end else begin
            elig  = m_pend & m_mask;
            first = -1;
            for (int i = 0; i < 4; i++) if (elig[i] && first < 0) first = i;
            tk = (m_state == 1) && take;
            for (int i = 0; i < 4; i++) begin
                if (m_edge[i]) begin
                    if (irq[i] && !m_prev[i])                          np[i] = 1'b1;
                    else if ((we && addr == 2 && wd[i]) || (tk && m_sel == i)) np[i] = 1'b0;
                    else                                               np[i] = m_pend[i];
                end else begin
                    np[i] = irq[i];
                end
            end
            m_ack = 0;
            if (m_state == 0) begin
                if (en && first >= 0) begin
                    m_state = 1; m_sel = first; m_vec = 32'h100 + 32'(first) * 16;
                end
            end else if (m_state == 1) begin
                if (tk) begin
                    m_pc = pc; m_aid = m_sel; m_ack = 1; m_state = 2;
                end else if (!en || first < 0) begin
                    m_state = 0;
                end else begin
                    m_sel = first; m_vec = 32'h100 + 32'(first) * 16;
                end
            end else if (ret) begin
                m_state = 0;
            end
            if (we && addr == 0) m_mask = wd[3:0];
            if (we && addr == 1) m_edge = wd[3:0];
            m_pend = np;
            m_prev = irq;
        end
        e.irr    = (m_state == 1);
        e.vec    = m_vec;
        e.pc     = m_pc;
        e.ack    = m_ack;
        e.active = (m_state == 2);
        e.aid    = 2'(m_aid);
        case (addr)
            2'd0:    e.rdata = 32'(m_mask);
            2'd1:    e.rdata = 32'(m_edge);
            2'd2:    e.rdata = 32'(m_pend);
            default: e.rdata = 32'(en) | (32'(e.active) << 1) | (32'(e.aid) << 8);
        endcase
        q.push_back(e);
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("irr",       32'(irr),       32'(e.irr));
                check("intr_vec",  intr_vec,       e.vec);
                check("intr_pc",   intr_pc,        e.pc);
                check("ack",       32'(ack),       32'(e.ack));
                check("active",    32'(active),    32'(e.active));
                check("active_id", 32'(active_id), 32'(e.aid));
                check("cfg_rdata", cfg_rdata,      e.rdata);
            end
        end
    end

    initial begin
        bit [3:0] irq_r;
        rst_n = 0; irq_in = 0; core_intr_en = 0; core_pc = 0;
        intr_take = 0; intr_ret = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;

        // Reset, single edge channel 2 through request, take and return.
        cyc(0, 0, 1, 0, 0, 0, 0, 3, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 32'h4);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 32'h4);
        cyc(1, 4, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 32'h40, 1, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 1, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 1, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 3, 0);

        // All-level, all-unmasked: no request while ch3 is being serviced.
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 32'hF);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 32'h0);
        cyc(1, 8, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 8, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 8, 1, 32'h200, 1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4'hA, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 4'hA, 1, 0, 0, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4'hA, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 32'h300, 1, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 1, 0, 3, 0);

        // W1C on the same edge as a new rise: the rise wins.
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 32'h0);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 32'hF);
        cyc(1, 1, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 1, 1, 0, 0, 0, 1, 2, 32'h1);
        cyc(1, 1, 1, 0, 0, 0, 0, 2, 0);

        // Request withdrawn by core_intr_en, then by W1C.
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 32'h1);
        cyc(1, 1, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 3, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 0, 1, 2, 32'hF);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);

        // Re-arbitration in REQ: ch0 overtakes ch2 before the take.
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 32'h5);
        cyc(1, 4, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 0, 1, 32'h80, 1, 0, 0, 2, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 3, 0);

        // Reset while ACTIVE; a later return must be ignored.
        cyc(0, 0, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 1, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 0);

        // Random traffic.
        irq_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_r = irq_r ^ 4'($urandom);
            cyc($urandom_range(0, 299) != 0, irq_r, $urandom_range(0, 9) != 0, $urandom,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, 2'($urandom), $urandom);
        end

        repeat (5) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
